rv32i_dx_slice: RTL and testbench



---
 rtl/rv32i_dx_slice.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_rv32i_dx_slice.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dx_slice.sv
// rv32i_dx_slice: RV32I decode/execute slice with its EX/MEM pipeline register.
//
// Decodes Instr_D, reads the 32x32 register file (written from writeback, with
// same-cycle write-through), applies the external forwarding selects, executes the
// ALU op, resolves branches/jumps combinationally, and registers the memory-stage
// bundle on the rising edge of CLK. RST is asynchronous, active-low.
//
// Ports:
//   CLK, RST                       clock, async active-low reset
//   Instr_D, PC_D, PC_Plus_4_D     fetched instruction and its PC / PC+4
//   Flush_E                        squash: bubble into M, no redirect
//   FWD_SrcA, FWD_SrcB             00 regfile, 01 Result_W, 10 ALU_Out_M (11 = 00)
//   REG_W_En_W, RD_W, Result_W     writeback port
//   RS1_D, RS2_D, RD_D             decoded register addresses
//   Branch_Taken_E, PC_Target_E    redirect request and target
//   *_M                            registered memory-stage bundle
//   FPGA_RED1/2, FPGA_GRN1/2       status LEDs
//
// Optional feature: define STATUS_LED_EN to latch the LEDs green on a decoded
// ECALL (0x00000073). Without it the LED outputs are constant 0.

module rv32i_dx_slice (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Instr_D,
    input  logic [31:0] PC_D,
    input  logic [31:0] PC_Plus_4_D,
    input  logic        Flush_E,
    input  logic [1:0]  FWD_SrcA,
    input  logic [1:0]  FWD_SrcB,
    input  logic        REG_W_En_W,
    input  logic [4:0]  RD_W,
    input  logic [31:0] Result_W,
    output logic [4:0]  RS1_D,
    output logic [4:0]  RS2_D,
    output logic [4:0]  RD_D,
    output logic        Branch_Taken_E,
    output logic [31:0] PC_Target_E,
    output logic        REG_W_En_M,
    output logic        MEM_W_En_M,
    output logic [2:0]  MEM_Control_M,
    output logic [1:0]  Result_Src_Sel_M,
    output logic [4:0]  RD_M,
    output logic [31:0] SrcB_Reg_M,
    output logic [31:0] ALU_Out_M,
    output logic [31:0] PC_Plus_4_M,
    output logic        FPGA_RED1,
    output logic        FPGA_RED2,
    output logic        FPGA_GRN1,
    output logic        FPGA_GRN2
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluSll   = 4'd2;
    localparam logic [3:0] AluSlt   = 4'd3;
    localparam logic [3:0] AluSltu  = 4'd4;
    localparam logic [3:0] AluXor   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluOr    = 4'd8;
    localparam logic [3:0] AluAnd   = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

    // ---------------------------------------------------------------- fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = Instr_D[6:0];
    assign funct3    = Instr_D[14:12];
    assign funct7_b5 = Instr_D[30];
    assign RS1_D     = Instr_D[19:15];
    assign RS2_D     = Instr_D[24:20];
    assign RD_D      = Instr_D[11:7];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{Instr_D[31]}}, Instr_D[31:20]};
    assign imm_s = {{20{Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
    assign imm_b = {{20{Instr_D[31]}}, Instr_D[7], Instr_D[30:25], Instr_D[11:8], 1'b0};
    assign imm_u = {Instr_D[31:12], 12'b0};
    assign imm_j = {{12{Instr_D[31]}}, Instr_D[19:12], Instr_D[20], Instr_D[30:21], 1'b0};

    // ------------------------------------------------------------------ decode
    // allow_sub is clear for I-ALU: funct7[5] there is part of the immediate,
    // except for SRAI where it selects the arithmetic shift.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt,
                                           input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    logic        reg_w_en, mem_w_en, b_is_imm, a_is_pc, is_branch, is_jump, is_jalr;
    logic [1:0]  result_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] imm;

    always_comb begin
        reg_w_en   = 1'b0;
        mem_w_en   = 1'b0;
        result_src = 2'b00;
        alu_ctrl   = AluAdd;
        b_is_imm   = 1'b1;
        a_is_pc    = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_jalr    = 1'b0;
        imm        = imm_i;
        case (opcode)
            OpR: begin
                reg_w_en = 1'b1;
                b_is_imm = 1'b0;
                alu_ctrl = alu_dec(funct3, funct7_b5, 1'b1);
            end
            OpI: begin
                reg_w_en = 1'b1;
                alu_ctrl = alu_dec(funct3, funct7_b5, 1'b0);
            end
            OpLoad: begin
                reg_w_en   = 1'b1;
                result_src = 2'b01;
            end
            OpStore: begin
                mem_w_en = 1'b1;
                imm      = imm_s;
            end
            OpBranch: begin
                is_branch = 1'b1;
                b_is_imm  = 1'b0;
                imm       = imm_b;
            end
            OpJal: begin
                reg_w_en   = 1'b1;
                result_src = 2'b10;
                is_jump    = 1'b1;
                imm        = imm_j;
            end
            OpJalr: begin
                reg_w_en   = 1'b1;
                result_src = 2'b10;
                is_jump    = 1'b1;
                is_jalr    = 1'b1;
            end
            OpLui: begin
                reg_w_en = 1'b1;
                alu_ctrl = AluPassB;
                imm      = imm_u;
            end
            OpAuipc: begin
                reg_w_en = 1'b1;
                a_is_pc  = 1'b1;
                imm      = imm_u;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------- register file
    logic [31:0] rf_q [32];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (REG_W_En_W && (RD_W != 5'd0)) begin
            rf_q[RD_W] <= Result_W;
        end
    end

    function automatic logic [31:0] rf_read(input logic [4:0] addr);
        if (addr == 5'd0)                       return '0;
        else if (REG_W_En_W && (RD_W == addr))  return Result_W;
        else                                    return rf_q[addr];
    endfunction

    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rf);
        case (sel)
            2'b01:   return Result_W;
            2'b10:   return ALU_Out_M;
            default: return rf;
        endcase
    endfunction

    logic [31:0] rs1_val, rs2_val, src_a, src_b;

    assign rs1_val = fwd_mux(FWD_SrcA, rf_read(RS1_D));
    assign rs2_val = fwd_mux(FWD_SrcB, rf_read(RS2_D));
    assign src_a   = a_is_pc  ? PC_D : rs1_val;
    assign src_b   = b_is_imm ? imm  : rs2_val;

    // --------------------------------------------------------------------- ALU
    logic [31:0] alu_out;
    logic [4:0]  shamt;

    assign shamt = src_b[4:0];

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            AluAdd:   alu_out = src_a + src_b;
            AluSub:   alu_out = src_a - src_b;
            AluSll:   alu_out = src_a << shamt;
            AluSlt:   alu_out = {31'b0, $signed(src_a) < $signed(src_b)};
            AluSltu:  alu_out = {31'b0, src_a < src_b};
            AluXor:   alu_out = src_a ^ src_b;
            AluSrl:   alu_out = src_a >> shamt;
            AluSra:   alu_out = $unsigned($signed(src_a) >>> shamt);
            AluOr:    alu_out = src_a | src_b;
            AluAnd:   alu_out = src_a & src_b;
            AluPassB: alu_out = src_b;
            default:  alu_out = '0;
        endcase
    end

    // ------------------------------------------------------------ branch/jump
    logic br_cond;

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_val == rs2_val);
            3'b001:  br_cond = (rs1_val != rs2_val);
            3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_cond = (rs1_val <  rs2_val);
            3'b111:  br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
    end

    assign Branch_Taken_E = ~Flush_E & (is_jump | (is_branch & br_cond));
    assign PC_Target_E    = is_jalr ? ((rs1_val + imm) & ~32'd1) : (PC_D + imm);

    // ------------------------------------------------------------ EX/MEM regs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            REG_W_En_M       <= 1'b0;
            MEM_W_En_M       <= 1'b0;
            MEM_Control_M    <= 3'b0;
            Result_Src_Sel_M <= 2'b0;
            RD_M             <= 5'b0;
            SrcB_Reg_M       <= '0;
            ALU_Out_M        <= '0;
            PC_Plus_4_M      <= '0;
        end else begin
            // A flushed instruction still loads its data fields; only the
            // enables are squashed, which makes it a harmless bubble.
            REG_W_En_M       <= reg_w_en & ~Flush_E;
            MEM_W_En_M       <= mem_w_en & ~Flush_E;
            MEM_Control_M    <= funct3;
            Result_Src_Sel_M <= result_src;
            RD_M             <= RD_D;
            SrcB_Reg_M       <= rs2_val;
            ALU_Out_M        <= alu_out;
            PC_Plus_4_M      <= PC_Plus_4_D;
        end
    end

    // ------------------------------------------------------------ status LEDs
`ifdef STATUS_LED_EN
    logic led_ok_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            led_ok_q <= 1'b0;
        end else if ((Instr_D == 32'h0000_0073) && !Flush_E) begin
            led_ok_q <= 1'b1;
        end
    end

    assign FPGA_RED1 = ~led_ok_q;
    assign FPGA_RED2 = ~led_ok_q;
    assign FPGA_GRN1 = led_ok_q;
    assign FPGA_GRN2 = led_ok_q;
`else
    assign FPGA_RED1 = 1'b0;
    assign FPGA_RED2 = 1'b0;
    assign FPGA_GRN1 = 1'b0;
    assign FPGA_GRN2 = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_dx_slice.sv
// Self-checking bench for rv32i_dx_slice. Expected EX/MEM bundles are pushed to a
// scoreboard when an instruction is driven and compared one edge later; the
// combinational decode/redirect outputs are checked directly after driving.

module tb_rv32i_dx_slice;

`ifdef STATUS_LED_EN
    localparam bit LedEn = 1'b1;
`else
    localparam bit LedEn = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Instr_D, PC_D, PC_Plus_4_D;
    logic        Flush_E;
    logic [1:0]  FWD_SrcA, FWD_SrcB;
    logic        REG_W_En_W;
    logic [4:0]  RD_W;
    logic [31:0] Result_W;
    logic [4:0]  RS1_D, RS2_D, RD_D;
    logic        Branch_Taken_E;
    logic [31:0] PC_Target_E;
    logic        REG_W_En_M, MEM_W_En_M;
    logic [2:0]  MEM_Control_M;
    logic [1:0]  Result_Src_Sel_M;
    logic [4:0]  RD_M;
    logic [31:0] SrcB_Reg_M, ALU_Out_M, PC_Plus_4_M;
    logic        FPGA_RED1, FPGA_RED2, FPGA_GRN1, FPGA_GRN2;

    always #5 CLK = ~CLK;

    rv32i_dx_slice dut (
        .CLK              (CLK),
        .RST              (RST),
        .Instr_D          (Instr_D),
        .PC_D             (PC_D),
        .PC_Plus_4_D      (PC_Plus_4_D),
        .Flush_E          (Flush_E),
        .FWD_SrcA         (FWD_SrcA),
        .FWD_SrcB         (FWD_SrcB),
        .REG_W_En_W       (REG_W_En_W),
        .RD_W             (RD_W),
        .Result_W         (Result_W),
        .RS1_D            (RS1_D),
        .RS2_D            (RS2_D),
        .RD_D             (RD_D),
        .Branch_Taken_E   (Branch_Taken_E),
        .PC_Target_E      (PC_Target_E),
        .REG_W_En_M       (REG_W_En_M),
        .MEM_W_En_M       (MEM_W_En_M),
        .MEM_Control_M    (MEM_Control_M),
        .Result_Src_Sel_M (Result_Src_Sel_M),
        .RD_M             (RD_M),
        .SrcB_Reg_M       (SrcB_Reg_M),
        .ALU_Out_M        (ALU_Out_M),
        .PC_Plus_4_M      (PC_Plus_4_M),
        .FPGA_RED1        (FPGA_RED1),
        .FPGA_RED2        (FPGA_RED2),
        .FPGA_GRN1        (FPGA_GRN1),
        .FPGA_GRN2        (FPGA_GRN2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // care bits: 0 rw, 1 mw, 2 mc, 3 rs, 4 rd, 5 alu, 6 srcb, 7 pc4
    typedef struct {
        string       tag;
        logic [7:0]  care;
        logic        rw;
        logic        mw;
        logic [2:0]  mc;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] srcb;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];

    task automatic push(input string tag, input logic [7:0] care, input logic rw,
                        input logic mw, input logic [2:0] mc, input logic [1:0] rs,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] srcb, input logic [31:0] pc4);
        exp_t e;
        e.tag = tag; e.care = care; e.rw = rw; e.mw = mw; e.mc = mc; e.rs = rs;
        e.rd = rd; e.alu = alu; e.srcb = srcb; e.pc4 = pc4;
        sb.push_back(e);
    endtask

    task automatic push_nop();
        push("nop", 8'h00, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [1:0] fa, input logic [1:0] fb, input logic fl);
        Instr_D     = instr;
        PC_D        = pc;
        PC_Plus_4_D = pc + 32'd4;
        FWD_SrcA    = fa;
        FWD_SrcB    = fb;
        Flush_E     = fl;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        REG_W_En_W = en;
        RD_W       = rd;
        Result_W   = d;
    endtask

    task automatic check_leds(input string tag, input logic green);
        logic [3:0] exp_leds;
        exp_leds = LedEn ? (green ? 4'b0011 : 4'b1100) : 4'b0000;
        check_eq(tag, {28'd0, FPGA_RED1, FPGA_RED2, FPGA_GRN1, FPGA_GRN2}, {28'd0, exp_leds});
    endtask

    task automatic check_m_zero(input string tag);
        check_eq({tag, ".en"}, {30'd0, REG_W_En_M, MEM_W_En_M}, 32'd0);
        check_eq({tag, ".ctl"}, {22'd0, MEM_Control_M, Result_Src_Sel_M, RD_M}, 32'd0);
        check_eq({tag, ".alu"}, ALU_Out_M, 32'd0);
        check_eq({tag, ".srcb"}, SrcB_Reg_M, 32'd0);
        check_eq({tag, ".pc4"}, PC_Plus_4_M, 32'd0);
    endtask

    // One rising edge, then compare the bundle the DUT registered on it.
    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.care[0]) check_eq({e.tag, ".rw"},   32'(REG_W_En_M),       32'(e.rw));
            if (e.care[1]) check_eq({e.tag, ".mw"},   32'(MEM_W_En_M),       32'(e.mw));
            if (e.care[2]) check_eq({e.tag, ".mc"},   32'(MEM_Control_M),    32'(e.mc));
            if (e.care[3]) check_eq({e.tag, ".rs"},   32'(Result_Src_Sel_M), 32'(e.rs));
            if (e.care[4]) check_eq({e.tag, ".rd"},   32'(RD_M),             32'(e.rd));
            if (e.care[5]) check_eq({e.tag, ".alu"},  ALU_Out_M,             e.alu);
            if (e.care[6]) check_eq({e.tag, ".srcb"}, SrcB_Reg_M,            e.srcb);
            if (e.care[7]) check_eq({e.tag, ".pc4"},  PC_Plus_4_M,           e.pc4);
        end
        REG_W_En_W = 1'b0;
    endtask

    initial begin
        RST = 1'b0;
        drive(32'd0, 32'd0, 2'b00, 2'b00, 1'b0);
        wb(1'b0, 5'd0, 32'd0);
        #1;
        check_m_zero("rst0");
        check_leds("rst0.led", 1'b0);
        @(negedge CLK);
        RST = 1'b1;

        // addi x1,x0,-5
        drive(32'hFFB00093, 32'h100, 2'b00, 2'b00, 1'b0);
        #1;
        check_eq("addi.rd_d", 32'(RD_D), 32'd1);
        check_eq("addi.rs1_d", 32'(RS1_D), 32'd0);
        check_eq("addi.rs2_d", 32'(RS2_D), 32'd27);
        check_eq("addi.bt", 32'(Branch_Taken_E), 32'd0);
        push("addi", 8'hFF, 1'b1, 1'b0, 3'b000, 2'b00, 5'd1, 32'hFFFF_FFFB, 32'd0, 32'h104);
        tick();

        // x2=7, then sub x4,x2,x3 with x3=3 written the same cycle; FWD 11 acts as 00
        drive(32'd0, 32'd0, 2'b00, 2'b00, 1'b0); wb(1'b1, 5'd2, 32'd7); push_nop(); tick();
        drive(32'h40310233, 32'h110, 2'b11, 2'b11, 1'b0); wb(1'b1, 5'd3, 32'd3);
        push("sub", 8'hFF, 1'b1, 1'b0, 3'b000, 2'b00, 5'd4, 32'd4, 32'd3, 32'h114);
        tick();

        // x3=4, x2=0x80000000 (write-through) for the shift/compare group
        drive(32'd0, 32'd0, 2'b00, 2'b00, 1'b0); wb(1'b1, 5'd3, 32'd4); push_nop(); tick();
        drive(32'h40315233, 32'h120, 2'b00, 2'b00, 1'b0); wb(1'b1, 5'd2, 32'h8000_0000);
        push("sra", 8'h70, 1'b1, 1'b0, 3'd0, 2'd0, 5'd4, 32'hF800_0000, 32'd4, 32'd0);
        tick();
        drive(32'h00315233, 32'h124, 2'b00, 2'b00, 1'b0);
        push("srl", 8'h20, 1'b1, 1'b0, 3'd0, 2'd0, 5'd4, 32'h0800_0000, 32'd0, 32'd0);
        tick();
        drive(32'h00312233, 32'h128, 2'b00, 2'b00, 1'b0);
        push("slt", 8'h20, 1'b1, 1'b0, 3'd0, 2'd0, 5'd4, 32'd1, 32'd0, 32'd0);
        tick();
        drive(32'h00313233, 32'h12C, 2'b00, 2'b00, 1'b0);
        push("sltu", 8'h20, 1'b1, 1'b0, 3'd0, 2'd0, 5'd4, 32'd0, 32'd0, 32'd0);
        tick();

        // add x5,x0,x0 while writeback targets x0: x0 must stay 0
        drive(32'h000002B3, 32'h130, 2'b00, 2'b00, 1'b0); wb(1'b1, 5'd0, 32'h55);
        push("x0", 8'h71, 1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'd0, 32'd0, 32'd0);
        tick();

        // lui, auipc, lw
        drive(32'h12345437, 32'h134, 2'b00, 2'b00, 1'b0);
        push("lui", 8'h39, 1'b1, 1'b0, 3'd0, 2'b00, 5'd8, 32'h1234_5000, 32'd0, 32'd0);
        tick();
        drive(32'h00001497, 32'h500, 2'b00, 2'b00, 1'b0);
        push("auipc", 8'h31, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h0000_1500, 32'd0, 32'd0);
        tick();
        drive(32'h00002503, 32'h504, 2'b00, 2'b00, 1'b0);
        push("lw", 8'h3F, 1'b1, 1'b0, 3'b010, 2'b01, 5'd10, 32'd0, 32'd0, 32'd0);
        tick();

        // beq x0,x0,+16 at 0x200, then flushed
        drive(32'h00000863, 32'h200, 2'b00, 2'b00, 1'b0);
        #1;
        check_eq("beq.bt", 32'(Branch_Taken_E), 32'd1);
        check_eq("beq.tgt", PC_Target_E, 32'h210);
        push("beq", 8'h03, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(32'h00000863, 32'h200, 2'b00, 2'b00, 1'b1);
        #1;
        check_eq("beqfl.bt", 32'(Branch_Taken_E), 32'd0);
        push_nop();
        tick();

        // bne not taken; blt signed taken; bltu not taken (x2=0x80000000, x3=4)
        drive(32'h00001863, 32'h220, 2'b00, 2'b00, 1'b0);
        #1;
        check_eq("bne.bt", 32'(Branch_Taken_E), 32'd0);
        drive(32'h00314863, 32'h230, 2'b00, 2'b00, 1'b0);
        #1;
        check_eq("blt.bt", 32'(Branch_Taken_E), 32'd1);
        check_eq("blt.tgt", PC_Target_E, 32'h240);
        drive(32'h00316863, 32'h240, 2'b00, 2'b00, 1'b0);
        #1;
        check_eq("bltu.bt", 32'(Branch_Taken_E), 32'd0);
        push_nop();
        tick();

        // flushed addi: enables squashed
        drive(32'hFFB00093, 32'h100, 2'b00, 2'b00, 1'b1);
        push("addifl", 8'h03, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();

        // addi x6,x0,0x301 then jalr x1,8(x5) forwarding ALU_Out_M
        drive(32'h30100313, 32'h3F0, 2'b00, 2'b00, 1'b0);
        push("addi301", 8'h30, 1'b1, 1'b0, 3'd0, 2'd0, 5'd6, 32'h301, 32'd0, 32'd0);
        tick();
        drive(32'h008280E7, 32'h400, 2'b10, 2'b00, 1'b0);
        #1;
        check_eq("jalr.bt", 32'(Branch_Taken_E), 32'd1);
        check_eq("jalr.tgt", PC_Target_E, 32'h308);
        push("jalr", 8'h99, 1'b1, 1'b0, 3'd0, 2'b10, 5'd1, 32'd0, 32'd0, 32'h404);
        tick();

        // jal x0,+8 at 0x600
        drive(32'h0080006F, 32'h600, 2'b00, 2'b00, 1'b0);
        #1;
        check_eq("jal.bt", 32'(Branch_Taken_E), 32'd1);
        check_eq("jal.tgt", PC_Target_E, 32'h608);
        push("jal", 8'h09, 1'b1, 1'b0, 3'd0, 2'b10, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();

        // sw x6,4(x7): x6 via writeback, x7 written the same cycle
        drive(32'd0, 32'd0, 2'b00, 2'b00, 1'b0); wb(1'b1, 5'd6, 32'hDEAD_BEEF); push_nop(); tick();
        drive(32'h0063A223, 32'h700, 2'b00, 2'b00, 1'b0); wb(1'b1, 5'd7, 32'h10);
        push("sw", 8'h67, 1'b0, 1'b1, 3'b010, 2'd0, 5'd0, 32'h14, 32'hDEAD_BEEF, 32'd0);
        tick();
        // same store with rs2 forwarded from Result_W
        drive(32'h0063A223, 32'h704, 2'b00, 2'b01, 1'b0); wb(1'b0, 5'd0, 32'hCAFE_F00D);
        push("swfwd", 8'h62, 1'b0, 1'b1, 3'd0, 2'd0, 5'd0, 32'h14, 32'hCAFE_F00D, 32'd0);
        tick();

        // reset mid-stream: asynchronous clear, register file cleared
        drive(32'hFFB00093, 32'h100, 2'b00, 2'b00, 1'b0);
        push_nop();
        #2;
        RST = 1'b0;
        #1;
        check_m_zero("rstmid");
        check_leds("rstmid.led", 1'b0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        drive(32'h000305B3, 32'h800, 2'b00, 2'b00, 1'b0);
        push("rfclr", 8'h71, 1'b1, 1'b0, 3'd0, 2'd0, 5'd11, 32'd0, 32'd0, 32'd0);
        tick();

        // ECALL: NOP to the pipeline; LEDs go green only with the LED feature built in
        drive(32'h0000_0073, 32'h804, 2'b00, 2'b00, 1'b0);
        push("ecall", 8'h03, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check_leds("ecall.led", 1'b1);
        drive(32'd0, 32'h808, 2'b00, 2'b00, 1'b0);
        push_nop();
        tick();
        check_leds("ledhold", 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
